// File: rtl/byte_inc_sched_package.sv
// Shared types for the byte-increment job scheduler: FSM state encoding,
// the job record and the busy-timeout constant.
package byte_inc_sched_package;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    // Widest address/length field a job record can carry.
    localparam int unsigned JOB_FIELD_W_MAX = 32;

    // Job record as seen by software: start word address and byte length.
    typedef struct packed {
        logic [JOB_FIELD_W_MAX-1:0] base_addr;
        logic [JOB_FIELD_W_MAX-1:0] length;
    } job_t;

    // Cycles with waitrequest low after run acceptance before the job is
    // assumed to have completed without the engine ever reporting busy.
    localparam int unsigned BUSY_TIMEOUT = 2;

endpackage

// File: rtl/byte_inc_sched_fifo.sv
// Single-clock show-ahead FIFO holding packed jobs. Head entry is visible on
// data_o whenever empty_o is low; pop_i consumes it.
module byte_inc_sched_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       srst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign full_o  = (count == DEPTH_CNT);
    assign empty_o = (count == '0);
    assign count_o = count;
    assign data_o  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/byte_inc_sched.sv
// Job scheduler in front of a byte-increment engine. Jobs are queued FIFO and
// issued one at a time with a run/waitrequest handshake.
// Handshake: a job is taken on a posedge where job_valid_i and job_ready_o are
// both high; a run is accepted on a posedge where run_o is high and
// waitrequest_i is low.
// Optional feature: define BYTE_INC_SCHED_STATS_EN to enable the jobs_done_o
// retired-job counter (otherwise it is tied to zero).
module byte_inc_sched
    import byte_inc_sched_package::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned QUEUE_DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic [ADDR_WIDTH-1:0] job_base_addr_i,
    input  logic [ADDR_WIDTH-1:0] job_length_i,
    input  logic                  job_valid_i,
    output logic                  job_ready_o,
    output logic [ADDR_WIDTH-1:0] base_addr_o,
    output logic [ADDR_WIDTH-1:0] length_o,
    output logic                  run_o,
    input  logic                  waitrequest_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           jobs_done_o,
    output logic [1:0]            state_o
);
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic [2*ADDR_WIDTH-1:0] head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    logic                    push;
    logic                    pop;
    state_t                  state;
    logic                    wb_cnt;

    // Ready depends only on the current occupancy, never on a same-cycle pop.
    assign job_ready_o = !fifo_full;
    assign push        = job_valid_i && job_ready_o;
    assign pop         = (state == ST_IDLE) && !fifo_empty;
    assign busy_o      = (fifo_count != '0) || (state != ST_IDLE);
    assign state_o     = state;

    byte_inc_sched_fifo #(
        .WIDTH (2*ADDR_WIDTH),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .srst_i  (srst_i),
        .push_i  (push),
        .data_i  ({job_base_addr_i, job_length_i}),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Scheduler FSM with registered run/done and job registers that stay
    // stable from ISSUE entry until the return to IDLE.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state       <= ST_IDLE;
            run_o       <= 1'b0;
            done_o      <= 1'b0;
            base_addr_o <= '0;
            length_o    <= '0;
            wb_cnt      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        base_addr_o <= head[2*ADDR_WIDTH-1:ADDR_WIDTH];
                        length_o    <= head[ADDR_WIDTH-1:0];
                        if (head[ADDR_WIDTH-1:0] == '0) begin
                            done_o <= 1'b1;
                        end else begin
                            run_o <= 1'b1;
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!waitrequest_i) begin
                        run_o  <= 1'b0;
                        wb_cnt <= 1'b0;
                        state  <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (waitrequest_i) begin
                        state <= ST_WAIT_DONE;
                    end else if (wb_cnt == 1'((BUSY_TIMEOUT - 1) & 1)) begin
                        done_o <= 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        wb_cnt <= wb_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!waitrequest_i) begin
                        done_o <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef BYTE_INC_SCHED_STATS_EN
    logic [15:0] jobs_done_q;

    // Retired-job counter, wraps naturally at 16 bits.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            jobs_done_q <= '0;
        end else if (done_o) begin
            jobs_done_q <= jobs_done_q + 16'd1;
        end
    end

    assign jobs_done_o = jobs_done_q;
`else
    assign jobs_done_o = '0;
`endif

endmodule

// File: tb/tb_byte_inc_sched.sv
// Self-checking bench for byte_inc_sched: FIFO-ordered job scoreboard,
// behavioural engine, run/done protocol and counter checks.
module tb_byte_inc_sched;

    localparam int AW = 10;
    localparam int QD = 8;

    logic          clk;
    logic          srst;
    logic [AW-1:0] job_base_addr;
    logic [AW-1:0] job_length;
    logic          job_valid;
    logic          job_ready;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] length;
    logic          run;
    logic          waitrequest;
    logic          busy;
    logic          done;
    logic [15:0]   jobs_done;
    logic [1:0]    state;

    byte_inc_sched #(
        .ADDR_WIDTH  (AW),
        .QUEUE_DEPTH (QD)
    ) dut (
        .clk_i           (clk),
        .srst_i          (srst),
        .job_base_addr_i (job_base_addr),
        .job_length_i    (job_length),
        .job_valid_i     (job_valid),
        .job_ready_o     (job_ready),
        .base_addr_o     (base_addr),
        .length_o        (length),
        .run_o           (run),
        .waitrequest_i   (waitrequest),
        .busy_o          (busy),
        .done_o          (done),
        .jobs_done_o     (jobs_done),
        .state_o         (state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int              checks = 0;
    int              errors = 0;
    logic [2*AW-1:0] exp_q[$];
    bit              job_open = 0;
    logic [AW-1:0]   open_base;
    logic [AW-1:0]   open_len;
    bit              prev_run = 0;
    int              done_total = 0;
    int              eng_lat = 0;
    bit              eng_hold = 0;
    bit              eng_rand = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] exp_jobs_done();
`ifdef BYTE_INC_SCHED_STATS_EN
        return 16'(done_total);
`else
        return 16'd0;
`endif
    endfunction

    // Behavioural engine: accepts run when not busy, then holds waitrequest
    // high for eng_lat cycles. eng_hold forces waitrequest high.
    initial begin
        int busy_cnt = 0;
        bit last_run = 0;
        waitrequest = 1'b0;
        forever begin
            @(negedge clk);
            if (srst) busy_cnt = 0;
            else if (last_run && !waitrequest) busy_cnt = eng_lat;
            else if (busy_cnt > 0) busy_cnt--;
            if (eng_rand) eng_hold = ($urandom_range(0, 3) == 0);
            waitrequest = eng_hold || (busy_cnt > 0);
            last_run = run;
        end
    end

    // Monitor / scoreboard: samples just after each posedge.
    initial begin
        logic [2*AW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (srst) begin
                check("rst_run", run, 0);
                check("rst_done", done, 0);
                check("rst_busy", busy, 0);
                check("rst_base", base_addr, 0);
                check("rst_len", length, 0);
                check("rst_jobs_done", jobs_done, 0);
                check("rst_ready", job_ready, 1);
                exp_q.delete();
                job_open = 0;
                done_total = 0;
            end else begin
                if (prev_run) begin
                    if (waitrequest) check("run_held", run, 1);
                    else             check("run_drop", run, 0);
                end
                check("jobs_done", jobs_done, exp_jobs_done());
                if (run && !prev_run) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_run", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("issue_base", base_addr, e[2*AW-1:AW]);
                        check("issue_len", length, e[AW-1:0]);
                        check("run_for_zero_len", (e[AW-1:0] == 0), 0);
                        job_open  = 1;
                        open_base = e[2*AW-1:AW];
                        open_len  = e[AW-1:0];
                    end
                end else if (job_open) begin
                    check("stable_base", base_addr, open_base);
                    check("stable_len", length, open_len);
                end
                if (done) begin
                    if (job_open) begin
                        job_open = 0;
                    end else if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("zlen_base", base_addr, e[2*AW-1:AW]);
                        check("zlen_len", length, e[AW-1:0]);
                    end
                    done_total++;
                end
                check("busy", busy, (job_open || exp_q.size() != 0));
            end
            prev_run = run;
        end
    end

    // Driver: offer one job starting at a negedge; returns at the negedge
    // after the handshake posedge.
    task automatic push_job(input logic [AW-1:0] b, input logic [AW-1:0] l, output int waits);
        job_base_addr = b;
        job_length    = l;
        job_valid     = 1'b1;
        waits = 0;
        while (!job_ready && waits < 3000) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 3000) check("push_timeout", 1, 0);
        else exp_q.push_back({b, l});
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || job_open || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", (n < 3000), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int w;
        int wsum;
        srst          = 1'b1;
        job_valid     = 1'b0;
        job_base_addr = '0;
        job_length    = '0;
        repeat (3) @(negedge clk);
        srst = 1'b0;
        @(negedge clk);

        // Single job, engine busy 5 cycles
        eng_lat = 5;
        push_job(10'h010, 10'd24, w);
        wait_drain();
        check("single_done_count", done_total, 1);

        // Engine holds waitrequest during ISSUE
        eng_lat = 2;
        eng_hold = 1;
        push_job(10'h020, 10'd7, w);
        repeat (4) @(negedge clk);
        check("issue_state", state, 1);
        check("issue_run_high", run, 1);
        eng_hold = 0;
        wait_drain();

        // Zero-length job followed by a normal job
        push_job(10'h030, 10'd0, w);
        push_job(10'h040, 10'd9, w);
        wait_drain();

        // Fill the queue behind a long-running job
        eng_lat = 60;
        push_job(10'h100, 10'd5, w);
        repeat (6) @(negedge clk);
        check("long_job_wait_done", state, 3);
        wsum = 0;
        for (int i = 0; i < QD + 1; i++) begin
            push_job(10'(10'h200 + i), 10'(i + 1), w);
            if (i < QD) wsum += w;
            if (i == QD - 1) check("ready_low_when_full", job_ready, 0);
            if (i == QD) check("ninth_held", (w > 0), 1);
        end
        check("first_eight_no_wait", wsum, 0);
        eng_lat = 1;
        wait_drain();

        // Reset in WAIT_DONE with three jobs queued
        eng_lat = 50;
        push_job(10'h300, 10'd4, w);
        repeat (6) @(negedge clk);
        check("pre_reset_wait_done", state, 3);
        for (int i = 0; i < 3; i++) push_job(10'(10'h310 + i), 10'd3, w);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        check("post_reset_busy", busy, 0);
        check("post_reset_ready", job_ready, 1);
        repeat (6) @(negedge clk);
        check("post_reset_idle", state, 0);

        // Randomised traffic
        eng_rand = 1;
        for (int i = 0; i < 40; i++) begin
            eng_lat = $urandom_range(0, 5);
            push_job(10'($urandom_range(0, 1023)),
                     ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023)), w);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        @(negedge clk);
        eng_rand = 0;
        eng_hold = 0;
        wait_drain();
        check("final_queue_empty", exp_q.size(), 0);
        check("final_jobs_done", jobs_done, exp_jobs_done());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_inc_sched.md
BYTE_INC_SCHED -- requirements
Module: byte_inc_sched

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: width of base address and length fields.
REQ-002 Parameter QUEUE_DEPTH, default 8: job queue entries; power of two, >= 2.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk_i  in  1  system clock.
REQ-005 srst_i  in  1  synchronous active-high reset.
REQ-006 job_base_addr_i  in  ADDR_WIDTH  job start word address.
REQ-007 job_length_i  in  ADDR_WIDTH  job length in bytes.
REQ-008 job_valid_i  in  1  job offered.
REQ-009 job_ready_o  out  1  queue can accept; job taken when valid and ready both high at posedge.
REQ-010 base_addr_o  out  ADDR_WIDTH  to engine base_addr_i.
REQ-011 length_o  out  ADDR_WIDTH  to engine length_i.
REQ-012 run_o  out  1  to engine run_i.
REQ-013 waitrequest_i  in  1  from engine waitrequest_o (high = engine busy).
REQ-014 busy_o  out  1  high when queue non-empty or FSM not IDLE.
REQ-015 done_o  out  1  one-cycle pulse per retired job.
REQ-016 jobs_done_o  out  16  retired-job counter (see Configuration).

Function
REQ-017 Jobs SHALL be queued FIFO-ordered; job_ready_o = (occupancy < QUEUE_DEPTH), registered from current occupancy only (a pop in the same cycle does not raise ready).
REQ-018 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE: if queue non-empty, pop head into output registers; length 0 -> pulse done_o next cycle, stay IDLE; else -> ISSUE.
REQ-020 ISSUE: run_o high; when waitrequest_i low at posedge, run accepted -> WAIT_BUSY; run_o low from next cycle.
REQ-021 WAIT_BUSY: waitrequest_i high -> WAIT_DONE; if still low after 2 cycles -> treat job as complete (done_o pulse) -> IDLE.
REQ-022 WAIT_DONE: waitrequest_i low -> done_o pulse same cycle as transition to IDLE.
REQ-023 base_addr_o/length_o SHALL stay stable from ISSUE entry until return to IDLE.
REQ-024 Min latency push -> run_o high: 2 cycles (no bypass of empty queue).
REQ-025 Push to empty queue while FSM busy SHALL be accepted; issue follows retirement of current job with one IDLE cycle.
REQ-026 Simultaneous push and pop SHALL keep occupancy unchanged.

Reset
REQ-027 srst_i SHALL empty the queue, force FSM to IDLE, zero run_o, done_o, busy_o, base_addr_o, length_o, jobs_done_o; job_ready_o high from first cycle after reset.
REQ-028 Reset mid-job SHALL abandon the job without done_o; engine in-flight state is not tracked.

Configuration
REQ-029 Macro BYTE_INC_SCHED_STATS_EN: defined -> jobs_done_o increments on every done_o, wraps 0xFFFF -> 0; undefined -> jobs_done_o tied 0, counter logic absent.

Structure
REQ-030 Package byte_inc_sched_package SHALL hold the FSM state enum and job struct typedef (base_addr, length).
REQ-031 Queue SHALL be a sub-module byte_inc_sched_fifo (single-clock, show-ahead, full/empty/count outputs).

Verification
REQ-032 Single job base 0x010, len 24, engine busy 5 cycles -> one run_o pulse, addr/len stable, one done_o, jobs_done_o=1 (STATS_EN).
REQ-033 Push QUEUE_DEPTH+1 back-to-back jobs, engine idle-blocked -> job_ready_o low after 8th, 9th held until a pop; jobs issued in push order.
REQ-034 Job with length 0 -> no run_o, done_o pulse, next queued job issued after.
REQ-035 waitrequest_i high 4 cycles during ISSUE -> run_o held high, accepted first low cycle.
REQ-036 srst_i during WAIT_DONE with 3 queued jobs -> all outputs zero next cycle, no done_o, queue empty.
REQ-037 Without BYTE_INC_SCHED_STATS_EN, 5 jobs retired -> jobs_done_o stays 0.
